alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Multi-cycle execution unit that consumes the 4-bit ALUControl code produced by the ALU decoder, together with SrcA/SrcB, and returns a registered result and zero flag. Non-shift operations complete in one cycle. Shifts are iterative, one bit per cycle, to save area. The unit sits in the execute stage behind a valid/ready handshake on both its input and output sides.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width; taken from SrcB[SHAMT_W-1:0]

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_control  input  4  operation code {funct7b5,funct3} / 1111 pass-B
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B / shift amount source
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
zero  output  1  registered (result == 0)
busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high, any state, including mid-shift): state=IDLE, out_valid=0, result=0, zero=0, shift counter=0. An in-flight operation is discarded.
- in_ready = (state==IDLE). An accept happens on an edge where in_valid && in_ready. Inputs are sampled only at the accept edge and may change afterwards.
- Op codes:
  - 0000 add, 1000 sub (both modulo 2^WIDTH).
  - 0001 sll, 0101 srl, 1101 sra.
  - 0010 slt (signed), 0011 sltu (unsigned); each yields 1 or 0 zero-extended.
  - 0100 xor, 0110 or, 0111 and.
  - 1111 result=src_b.
  - Any other code (1001,1010,1011,1100,1110): result=0, one-cycle latency.
- States: IDLE, SHIFT, DONE.
- Non-shift accept: result and zero are registered at the accept edge, state->DONE. out_valid is high the following cycle (latency 1).
- Shift accept with n=src_b[SHAMT_W-1:0]:
  - n==0: result=src_a, state->DONE (latency 1).
  - n>=1: load src_a into the working register, counter=n, state->SHIFT.
  - Each SHIFT edge shifts one bit (sll: zero into LSB; srl: zero into MSB; sra: copy MSB) and decrements the counter. When the counter reaches 0, result and zero are updated and state->DONE.
  - out_valid rises n+1 edges after the accept edge.
- DONE: out_valid=1. result and zero are held stable while out_ready=0. The edge with out_ready=1 moves state->IDLE and drops out_valid. There is no back-to-back accept in the same cycle; the next accept is possible one cycle later.
- SHIFT ignores in_valid; in_ready=0 throughout.
- src_b bits above SHAMT_W-1 are ignored for shifts.
- zero reflects the final result only and is never updated mid-shift.
- busy=1 in SHIFT and DONE.

Test Plan:
- Reset, then add: src_a=5, src_b=7, ctrl=0000 -> one cycle after accept out_valid=1, result=12, zero=0. Then sub 7-7 (1000) -> result=0, zero=1.
- slt vs sltu: a=0xFFFFFFFF, b=1 -> slt result=1, sltu result=0. 1111 with b=0xDEADBEEF -> result=0xDEADBEEF.
- Shifts:
  - sra a=0x80000000, b=4 -> out_valid exactly 5 edges after accept, result=0xF8000000.
  - srl same operands -> 0x08000000.
  - sll a=1, b=31 -> 0x80000000 after 32 edges.
- Shift by 0 and masking: sll a=0x1234, b=0x20 (masked to 0) -> result=0x1234, latency 1. in_ready=0 for every cycle of a 10-bit shift, and a concurrently held in_valid is not accepted.
- Backpressure: hold out_ready=0 for 6 cycles after an xor (a=0xF0F0, b=0x0FF0 -> 0xFF00) -> result, zero and out_valid are stable throughout. Releasing out_ready returns the unit to IDLE with in_ready=1 the next cycle.
- Reset mid-shift (sll b=20, reset asserted at 8th shift edge) -> next cycle state IDLE, out_valid=0, result=0, in_ready=1. A subsequent and a=0xFF, b=0x0F -> 0x0F.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish at accept; shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SLL   = 4'b0001,
    OP_SLT   = 4'b0010,
    OP_SLTU  = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_AND   = 4'b0111,
    OP_SUB   = 4'b1000,
    OP_SRA   = 4'b1101,
    OP_PASSB = 4'b1111
  } op_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_work, w_work_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_zero, w_zero_nxt;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]         r_op, w_op_nxt;

  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_step;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;

  assign w_shamt    = src_b[SHAMT_W-1:0];
  assign w_is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                      (alu_control == OP_SRA);

  // Shift codes evaluate to src_a here; that value is only used for a zero shift amount.
  always_comb begin
    w_alu = '0;
    case (alu_control)
      OP_ADD:   w_alu = src_a + src_b;
      OP_SUB:   w_alu = src_a - src_b;
      OP_SLT:   w_alu = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_XOR:   w_alu = src_a ^ src_b;
      OP_OR:    w_alu = src_a | src_b;
      OP_AND:   w_alu = src_a & src_b;
      OP_PASSB: w_alu = src_b;
      OP_SLL,
      OP_SRL,
      OP_SRA:   w_alu = src_a;
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    w_step = {1'b0, r_work[WIDTH-1:1]};
    case (r_op)
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_step = {1'b0, r_work[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_work_nxt  = src_a;
            w_cnt_nxt   = w_shamt;
            w_op_nxt    = alu_control;
            w_state_nxt = S_SHIFT;
          end else begin
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_state_nxt  = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        w_work_nxt = w_step;
        w_cnt_nxt  = r_cnt - 1'b1;
        // Last step publishes result/zero; they stay untouched on earlier steps.
        if (r_cnt == SHAMT_W'(1)) begin
          w_result_nxt = w_step;
          w_zero_nxt   = (w_step == '0);
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_op     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: transaction-level reference model checked
// every cycle, plus literal expectations per directed vector.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(ctrl_i),
    .src_a      (a_i),
    .src_b      (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
  endtask

  function automatic logic [31:0] model_res(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned n;
    n = b[4:0];
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << n;
      4'b0101: return a >> n;
      4'b1101: return $unsigned($signed(a) >>> n);
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1111: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Transaction model: tracks whether a result is pending/valid and how many edges remain.
  bit          m_started = 1'b0;
  bit          m_active  = 1'b0;
  bit          m_valid   = 1'b0;
  int          m_cnt     = 0;
  logic [31:0] m_res     = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active  = 1'b0;
      m_valid   = 1'b0;
      m_cnt     = 0;
      m_started = 1'b1;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid  = 1'b0;
        m_active = 1'b0;
      end
    end else if (m_active) begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1'b1;
    end else if (in_valid) begin
      m_res    = model_res(ctrl_i, a_i, b_i);
      m_active = 1'b1;
      m_cnt    = model_lat(ctrl_i, b_i) - 1;
      if (m_cnt == 0) m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_in_ready", 32'(in_ready), 32'(!m_active));
      chk("model_busy", 32'(busy), 32'(m_active));
      if (m_valid) begin
        chk("model_result", result, m_res);
        chk("model_zero", 32'(zero), 32'(m_res == 32'd0));
      end
    end
  end

  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold_valid, input int bp);
    int k;
    int lat;
    int seen_rdy;
    @(negedge clk);
    ctrl_i    = c;
    a_i       = a;
    b_i       = b;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      timeout_fail({nm, "_accept"});
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    a_i = $urandom;
    b_i = $urandom;
    if (hold_valid) ctrl_i = 4'b0000;
    else in_valid = 1'b0;
    lat = 1;
    seen_rdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (in_ready) seen_rdy++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      timeout_fail({nm, "_result"});
    end else begin
      chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_result"}, result, exp);
      chk({nm, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    end
    if (hold_valid) chk({nm, "_in_ready_while_busy"}, 32'(seen_rdy), 32'd0);
    if (bp > 0) begin
      repeat (bp) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_hold_result"}, result, exp);
        chk({nm, "_hold_zero"}, 32'(zero), 32'(exp == 32'd0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_release_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_release_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ctrl_i    = 4'b0000;
    a_i       = '0;
    b_i       = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_op("add",     4'b0000, 32'd5,          32'd7,          32'd12,         1,  1'b0, 0);
    run_op("sub",     4'b1000, 32'd7,          32'd7,          32'd0,          1,  1'b0, 0);
    run_op("slt",     4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1,  1'b0, 0);
    run_op("sltu",    4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1,  1'b0, 0);
    run_op("passb",   4'b1111, 32'h1111_2222,  32'hDEAD_BEEF,  32'hDEAD_BEEF,  1,  1'b0, 0);
    run_op("illegal", 4'b1010, 32'h1234_5678,  32'h0000_0001,  32'd0,          1,  1'b0, 0);
    run_op("or",      4'b0110, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1,  1'b0, 0);
    run_op("sra",     4'b1101, 32'h8000_0000,  32'd4,          32'hF800_0000,  5,  1'b0, 0);
    run_op("srl",     4'b0101, 32'h8000_0000,  32'd4,          32'h0800_0000,  5,  1'b0, 0);
    run_op("sll31",   4'b0001, 32'h0000_0001,  32'd31,         32'h8000_0000,  32, 1'b0, 0);
    run_op("sll_m0",  4'b0001, 32'h0000_1234,  32'h0000_0020,  32'h0000_1234,  1,  1'b0, 0);
    run_op("srl10",   4'b0101, 32'hFFFF_0000,  32'd10,         32'h003F_FFC0,  11, 1'b1, 0);
    run_op("xor_bp",  4'b0100, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1,  1'b0, 6);

    // Reset lands on the 8th shift edge of a 20-bit shift.
    @(negedge clk);
    ctrl_i   = 4'b0001;
    a_i      = 32'h0000_0003;
    b_i      = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("midshift_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midshift_out_valid", 32'(out_valid), 32'd0);
    chk("midshift_result", result, 32'd0);
    chk("midshift_zero", 32'(zero), 32'd0);
    chk("midshift_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    run_op("and",     4'b0111, 32'h0000_00FF,  32'h0000_000F,  32'h0000_000F,  1,  1'b0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
